// File: rtl/serial_add_arbiter.sv
// serial_add_arbiter: two requesters share one full adder, which is sequenced
// bit-serially (LSB first) with the carry held in a flip-flop between bits.
// Simultaneous requests are resolved round-robin.

// Single-bit full adder cell; the only arithmetic in the block.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_add_arbiter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             cin0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic             cin1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             busy,
    output logic             done,
    output logic             owner,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int unsigned      CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] SUM_MSB  = WIDTH'(1) << (WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state, state_nx;
    logic [WIDTH-1:0] ra, ra_nx;
    logic [WIDTH-1:0] rb, rb_nx;
    logic [WIDTH-1:0] rs, rs_nx;
    logic             carry, carry_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             last_srv, last_srv_nx;   // requester served most recently
    logic             cur, cur_nx;             // owner of the add in flight
    logic             gnt0_nx, gnt1_nx, busy_nx, done_nx, owner_nx, cout_nx;
    logic [WIDTH-1:0] sum_nx;
    logic             pick1;
    logic             fa_s, fa_co;

    // The single shared adder cell works on the current LSBs and stored carry.
    full_adder u_fa (
        .a  (ra[0]),
        .b  (rb[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    // Requester 1 wins when alone, or on a tie when requester 0 was served last.
    assign pick1 = req1 & (~req0 | ~last_srv);

    // Next-state, datapath and output decode.
    always_comb begin
        state_nx    = state;
        ra_nx       = ra;
        rb_nx       = rb;
        rs_nx       = rs;
        carry_nx    = carry;
        cnt_nx      = cnt;
        last_srv_nx = last_srv;
        cur_nx      = cur;
        sum_nx      = sum;
        cout_nx     = cout;
        owner_nx    = owner;
        gnt0_nx     = 1'b0;
        gnt1_nx     = 1'b0;
        done_nx     = 1'b0;

        case (state)
            S_IDLE: begin
                if (req0 || req1) begin
                    state_nx    = S_RUN;
                    cnt_nx      = '0;
                    rs_nx       = '0;
                    last_srv_nx = pick1;
                    cur_nx      = pick1;
                    if (pick1) begin
                        gnt1_nx  = 1'b1;
                        ra_nx    = a1;
                        rb_nx    = b1;
                        carry_nx = cin1;
                    end else begin
                        gnt0_nx  = 1'b1;
                        ra_nx    = a0;
                        rb_nx    = b0;
                        carry_nx = cin0;
                    end
                end
            end
            S_RUN: begin
                ra_nx    = ra >> 1;
                rb_nx    = rb >> 1;
                rs_nx    = (rs >> 1) | (fa_s ? SUM_MSB : '0);
                carry_nx = fa_co;
                if (cnt == CNT_LAST) begin
                    state_nx = S_DONE;
                    sum_nx   = rs_nx;
                    cout_nx  = fa_co;
                    owner_nx = cur;
                    done_nx  = 1'b1;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase

        busy_nx = (state_nx != S_IDLE);
    end

    // State, datapath and registered outputs; reset aborts any add in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            ra       <= '0;
            rb       <= '0;
            rs       <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            last_srv <= 1'b1;
            cur      <= 1'b0;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            owner    <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
        end else begin
            state    <= state_nx;
            ra       <= ra_nx;
            rb       <= rb_nx;
            rs       <= rs_nx;
            carry    <= carry_nx;
            cnt      <= cnt_nx;
            last_srv <= last_srv_nx;
            cur      <= cur_nx;
            gnt0     <= gnt0_nx;
            gnt1     <= gnt1_nx;
            busy     <= busy_nx;
            done     <= done_nx;
            owner    <= owner_nx;
            sum      <= sum_nx;
            cout     <= cout_nx;
        end
    end
endmodule

// File: tb/tb_serial_add_arbiter.sv
// Scoreboard bench for serial_add_arbiter: an 8-bit instance and a 1-bit instance.
module tb_serial_add_arbiter;
    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // 8-bit instance
    logic         req0 = 1'b0, req1 = 1'b0, cin0 = 1'b0, cin1 = 1'b0;
    logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic         gnt0, gnt1, busy, done, owner, cout;
    logic [W-1:0] sum;

    // 1-bit instance
    logic w1_req0 = 1'b0, w1_req1 = 1'b0, w1_cin0 = 1'b0, w1_cin1 = 1'b0;
    logic [0:0] w1_a0 = '0, w1_b0 = '0, w1_a1 = '0, w1_b1 = '0;
    logic w1_gnt0, w1_gnt1, w1_busy, w1_done, w1_owner, w1_cout;
    logic [0:0] w1_sum;

    serial_add_arbiter #(.WIDTH(W)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .a0(a0), .b0(b0), .cin0(cin0),
        .req1(req1), .a1(a1), .b1(b1), .cin1(cin1),
        .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done),
        .owner(owner), .sum(sum), .cout(cout)
    );

    serial_add_arbiter #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req0(w1_req0), .a0(w1_a0), .b0(w1_b0), .cin0(w1_cin0),
        .req1(w1_req1), .a1(w1_a1), .b1(w1_b1), .cin1(w1_cin1),
        .gnt0(w1_gnt0), .gnt1(w1_gnt1), .busy(w1_busy), .done(w1_done),
        .owner(w1_owner), .sum(w1_sum), .cout(w1_cout)
    );

    typedef struct {
        logic         own;
        logic         co;
        logic [W-1:0] s;
    } exp_t;

    exp_t       rq[$];     // expected results, 8-bit instance
    int         gq[$];     // expected grant order, 8-bit instance
    logic [1:0] q1[$];     // expected {cout, sum}, 1-bit instance

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_g = 0;
    int last_g1 = 0;
    int phase_id = 0;
    int seen_phase = -1;
    bit chk_period = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor for the 8-bit instance.
    always @(negedge clk) begin
        exp_t e;
        int   g;
        if (rst_n) begin
            checks++;
            if ((gnt0 && gnt1) || (done && (gnt0 || gnt1))) begin
                errors++;
                $display("FAIL exclusive: gnt0=%0b gnt1=%0b done=%0b, required at most one high", gnt0, gnt1, done);
            end
            if (gnt0 || gnt1) begin
                checks++;
                if (gq.size() == 0) begin
                    errors++;
                    $display("FAIL grant: unexpected grant gnt1=%0b at cycle %0d, required none", gnt1, cyc);
                end else begin
                    g = gq.pop_front();
                    if (int'(gnt1) != g) begin
                        errors++;
                        $display("FAIL grant_owner: got requester %0d, required %0d", int'(gnt1), g);
                    end
                end
                if (chk_period) begin
                    if (seen_phase == phase_id) begin
                        checks++;
                        if (cyc - last_g != int'(W) + 2) begin
                            errors++;
                            $display("FAIL grant_period: got %0d cycles, required %0d", cyc - last_g, W + 2);
                        end
                    end else begin
                        seen_phase = phase_id;
                    end
                end
                last_g = cyc;
            end
            if (done) begin
                checks++;
                if (cyc - last_g != int'(W)) begin
                    errors++;
                    $display("FAIL done_latency: got %0d cycles after grant, required %0d", cyc - last_g, W);
                end
                checks++;
                if (rq.size() == 0) begin
                    errors++;
                    $display("FAIL result: unexpected done owner=%0d sum=%0h cout=%0b, required none", owner, sum, cout);
                end else begin
                    e = rq.pop_front();
                    if (owner !== e.own || sum !== e.s || cout !== e.co) begin
                        errors++;
                        $display("FAIL result: got owner=%0d sum=%02h cout=%0b, required owner=%0d sum=%02h cout=%0b",
                                 owner, sum, cout, e.own, e.s, e.co);
                    end
                end
            end
        end
    end

    // Monitor for the 1-bit instance.
    always @(negedge clk) begin
        logic [1:0] e1;
        if (rst_n) begin
            if (w1_gnt0 || w1_gnt1) last_g1 = cyc;
            if (w1_done) begin
                checks++;
                if (cyc - last_g1 != 1) begin
                    errors++;
                    $display("FAIL w1_latency: got %0d cycles after grant, required 1", cyc - last_g1);
                end
                checks++;
                if (q1.size() == 0) begin
                    errors++;
                    $display("FAIL w1_result: unexpected done sum=%0b cout=%0b", w1_sum, w1_cout);
                end else begin
                    e1 = q1.pop_front();
                    if ({w1_cout, w1_sum} !== e1 || w1_owner !== 1'b0) begin
                        errors++;
                        $display("FAIL w1_result: got cout=%0b sum=%0b owner=%0d, required cout=%0b sum=%0b owner=0",
                                 w1_cout, w1_sum, w1_owner, e1[1], e1[0]);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_gnt0"}, int'(gnt0), 0);
        chk({tag, "_gnt1"}, int'(gnt1), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_owner"}, int'(owner), 0);
        chk({tag, "_sum"}, int'(sum), 0);
        chk({tag, "_cout"}, int'(cout), 0);
    endtask

    task automatic wait_gnt(input int n);
        bit ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if ((n == 0 && gnt0) || (n == 1 && gnt1)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wait_gnt: no grant to requester %0d within 40 cycles", n);
        end
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (!busy && !done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: busy still high after 40 cycles");
        end
    endtask

    // One request on requester n with hand-supplied expected result.
    task automatic single(input int n, input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          input logic [W-1:0] es, input logic ec);
        exp_t e;
        e.own = n[0]; e.s = es; e.co = ec;
        gq.push_back(n);
        rq.push_back(e);
        if (n == 0) begin a0 = a; b0 = b; cin0 = c; req0 = 1'b1; end
        else        begin a1 = a; b1 = b; cin1 = c; req1 = 1'b1; end
        wait_gnt(n);
        req0 = 1'b0;
        req1 = 1'b0;
        wait_idle();
    endtask

    initial begin
        exp_t e;
        logic [W:0] tot;
        logic [W-1:0] ra, rb;
        logic rc;
        int   ng;

        // Reset state
        #12;
        check_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single add and overflow
        single(0, 8'hA5, 8'h3C, 1'b0, 8'hE1, 1'b0);
        single(1, 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1);

        // Arbitration: both held; requester 1 was served last, so 0 wins first.
        phase_id++;
        chk_period = 1'b1;
        a0 = 8'h12; b0 = 8'h34; cin0 = 1'b0;
        a1 = 8'h80; b1 = 8'h80; cin1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            gq.push_back(i % 2);
            e.own = 1'(i % 2);
            e.s   = (i % 2 == 0) ? 8'h46 : 8'h01;
            e.co  = (i % 2 == 0) ? 1'b0 : 1'b1;
            rq.push_back(e);
        end
        req0 = 1'b1; req1 = 1'b1;
        ng = 0;
        for (int i = 0; i < 60 && ng < 4; i++) begin
            @(posedge clk); #1;
            if (gnt0 || gnt1) ng++;
        end
        req0 = 1'b0; req1 = 1'b0;
        chk("arb_grants", ng, 4);
        wait_idle();

        // Single requester held high
        phase_id++;
        a1 = 8'h7F; b1 = 8'h7F; cin1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            gq.push_back(1);
            e.own = 1'b1; e.s = 8'hFE; e.co = 1'b0;
            rq.push_back(e);
        end
        req1 = 1'b1;
        ng = 0;
        for (int i = 0; i < 60 && ng < 3; i++) begin
            @(posedge clk); #1;
            if (gnt1) ng++;
        end
        req1 = 1'b0;
        chk("single_req_grants", ng, 3);
        wait_idle();
        chk_period = 1'b0;

        // Reset in the middle of a run; the held request is re-granted afterwards.
        a0 = 8'h5A; b0 = 8'h33; cin0 = 1'b0;
        gq.push_back(0);
        req0 = 1'b1;
        wait_gnt(0);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrun_reset");
        gq.push_back(0);
        e.own = 1'b0; e.s = 8'h8D; e.co = 1'b0;
        rq.push_back(e);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_gnt(0);
        req0 = 1'b0;
        wait_idle();

        // Model-checked random adds, alternating requesters
        for (int i = 0; i < 16; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            tot = (W + 1)'(ra) + (W + 1)'(rb) + (W + 1)'(rc);
            single(i % 2, ra, rb, rc, tot[W-1:0], tot[W]);
        end

        // 1-bit instance: all operand combinations, 1,1,1 first
        for (int i = 7; i >= 0; i--) begin
            w1_a0 = 1'(i >> 2);
            w1_b0 = 1'(i >> 1);
            w1_cin0 = 1'(i);
            q1.push_back(2'(w1_a0) + 2'(w1_b0) + 2'(w1_cin0));
            w1_req0 = 1'b1;
            ng = 0;
            for (int k = 0; k < 20 && ng == 0; k++) begin
                @(posedge clk); #1;
                if (w1_gnt0) ng = 1;
            end
            w1_req0 = 1'b0;
            chk("w1_grant", ng, 1);
            repeat (4) @(posedge clk);
            #1;
        end

        // Drain: every expectation must have been consumed
        repeat (5) @(posedge clk);
        #1;
        chk("rq_drained", rq.size(), 0);
        chk("gq_drained", gq.size(), 0);
        chk("q1_drained", q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
